// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART clocking blocks.
package uart_pkg;

  localparam int unsigned ACC_WIDTH_DEFAULT     = 16;
  localparam int unsigned OVERSAMP_RATE_DEFAULT = 16;

  // 115200 baud x16 oversampling at 100 MHz with a 16-bit accumulator.
  localparam logic [15:0] DEFAULT_INC = 16'd1208;

  // Rounded phase increment for a target baud rate: baud*osr*2^acc_w/clk_hz.
  function automatic longint unsigned baud_inc(input longint unsigned clk_hz,
                                               input longint unsigned baud,
                                               input longint unsigned osr,
                                               input int unsigned     acc_w);
    longint unsigned num;
    num = (baud * osr) << acc_w;
    return (num + (clk_hz / 2)) / clk_hz;
  endfunction

endpackage

// File: rtl/phase_acc.sv
// Phase accumulator: adds inc every enabled cycle and flags the overflow carry.
module phase_acc #(
  parameter int unsigned ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [ACC_WIDTH-1:0] inc,
  output logic                 carry
);

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH:0]   sum;

  assign sum   = {1'b0, acc_q} + {1'b0, inc};
  // Clear wins over enable, so a resync cycle never produces a tick.
  assign carry = en && !clr && sum[ACC_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= sum[ACC_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional-N baud tick generator with oversample counter, resync and
// a handshaked increment that is swapped in only on bit boundaries.
module baud_gen_frac #(
  parameter int unsigned           ACC_WIDTH     = uart_pkg::ACC_WIDTH_DEFAULT,
  parameter int unsigned           OVERSAMP_RATE = uart_pkg::OVERSAMP_RATE_DEFAULT,
  parameter logic [ACC_WIDTH-1:0]  DEFAULT_INC   = ACC_WIDTH'(uart_pkg::DEFAULT_INC),
  parameter int unsigned           RESYNC_PHASE  = OVERSAMP_RATE / 2
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 enable_i,
  input  logic                 resync_i,
  input  logic [ACC_WIDTH-1:0] cfg_inc_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  output logic                 clk16_en_o,
  output logic                 clk_en_o
);

  localparam int unsigned   OsW    = (OVERSAMP_RATE > 2) ? $clog2(OVERSAMP_RATE) : 1;
  localparam logic [OsW-1:0] OsMax = OsW'(OVERSAMP_RATE - 1);
  localparam logic [OsW-1:0] OsRes = OsW'(RESYNC_PHASE);

  logic [ACC_WIDTH-1:0] inc_q;
  logic [ACC_WIDTH-1:0] pend_q;
  logic                 pend_valid_q;
  logic [OsW-1:0]       os_cnt_q;
  logic                 clk16_en_q;
  logic                 clk_en_q;
  logic                 carry;
  logic                 bit_tick;
  logic                 apply;

  phase_acc #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_phase_acc (
    .clk   (clk_i),
    .rst_n (reset_n_i),
    .en    (enable_i),
    .clr   (resync_i),
    .inc   (inc_q),
    .carry (carry)
  );

  always_comb begin
    bit_tick = carry && (os_cnt_q == OsMax);
    // Swap only where it cannot stretch a bit: at the boundary, while idle, or on resync.
    apply    = pend_valid_q && (resync_i || !enable_i || bit_tick);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      inc_q        <= DEFAULT_INC;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      os_cnt_q     <= '0;
      clk16_en_q   <= 1'b0;
      clk_en_q     <= 1'b0;
    end else begin
      clk16_en_q <= carry;
      clk_en_q   <= bit_tick;

      if (resync_i) begin
        os_cnt_q <= OsRes;
      end else if (carry) begin
        os_cnt_q <= (os_cnt_q == OsMax) ? '0 : os_cnt_q + OsW'(1);
      end

      if (apply) begin
        inc_q        <= pend_q;
        pend_valid_q <= 1'b0;
      end else if (cfg_valid_i && !pend_valid_q) begin
        pend_q       <= cfg_inc_i;
        pend_valid_q <= 1'b1;
      end
    end
  end

  assign cfg_ready_o = !pend_valid_q;
  assign clk16_en_o  = clk16_en_q;
  assign clk_en_o    = clk_en_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed self-checking bench for baud_gen_frac with hand-computed tick counts.
module tb_baud_gen_frac;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        resync;
  logic [15:0] cfg_inc;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        clk16_en;
  logic        clk_en;

  int total  = 0;
  int bad    = 0;
  int orphan = 0;

  baud_gen_frac dut (
    .clk_i       (clk),
    .reset_n_i   (rst_n),
    .enable_i    (enable),
    .resync_i    (resync),
    .cfg_inc_i   (cfg_inc),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .clk16_en_o  (clk16_en),
    .clk_en_o    (clk_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs n edges; counts pulses and records the 1-based edge index of the first of each.
  task automatic run_count(input int n, output int c16, output int cb,
                           output int f16, output int fb);
    c16 = 0; cb = 0; f16 = 0; fb = 0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (clk16_en) begin
        c16++;
        if (f16 == 0) f16 = i;
      end
      if (clk_en) begin
        cb++;
        if (fb == 0) fb = i;
        if (!clk16_en) orphan++;
      end
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    enable    = 1'b0;
    resync    = 1'b0;
    cfg_valid = 1'b0;
    cfg_inc   = '0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  // One handshake; the capture consumes exactly one clock edge.
  task automatic cfg_send(input logic [15:0] val);
    int n = 0;
    while (!cfg_ready && n < 200) begin
      step();
      n++;
    end
    if (!cfg_ready) check("cfg_ready_timeout", 0, 1);
    cfg_inc   = val;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  // Load while disabled: capture edge plus the application edge.
  task automatic cfg_load_idle(input logic [15:0] val);
    cfg_send(val);
    step();
  endtask

  int c16, cb, f16, fb;

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    resync    = 1'b0;
    cfg_valid = 1'b0;
    cfg_inc   = '0;
    repeat (3) step();
    check("rst_clk16", clk16_en, 0);
    check("rst_clk_en", clk_en, 0);
    check("rst_ready", cfg_ready, 1);

    // Default inc=1208 over 2^16 edges: exactly 1208 oversample ticks, 75 bit ticks.
    do_reset();
    enable = 1'b1;
    run_count(65536, c16, cb, f16, fb);
    check("def_c16", c16, 1208);
    check("def_cb", cb, 75);
    check("def_first16", f16, 55);
    check("def_firstb", fb, 869);

    // inc=32768 loaded while idle.
    do_reset();
    cfg_send(16'd32768);
    check("hs_ready_low", cfg_ready, 0);
    step();
    check("hs_ready_back", cfg_ready, 1);
    enable = 1'b1;
    run_count(32, c16, cb, f16, fb);
    check("h32_c16", c16, 16);
    check("h32_cb", cb, 1);
    check("h32_first16", f16, 2);
    check("h32_firstb", fb, 32);
    run_count(32, c16, cb, f16, fb);
    check("h32_c16_2", c16, 16);
    check("h32_firstb_2", fb, 32);

    // inc=0 while running: current bit finishes, then silence.
    cfg_send(16'd0);
    check("z_ready_low", cfg_ready, 0);
    run_count(31, c16, cb, f16, fb);
    check("z_c16_tail", c16, 16);
    check("z_firstb_tail", fb, 31);
    check("z_ready_back", cfg_ready, 1);
    run_count(64, c16, cb, f16, fb);
    check("z_c16_after", c16, 0);
    check("z_cb_after", cb, 0);

    // Mid-bit change to 16384; valid while not ready must be ignored.
    do_reset();
    cfg_load_idle(16'd32768);
    enable = 1'b1;
    run_count(10, c16, cb, f16, fb);
    cfg_send(16'd16384);
    cfg_inc   = 16'd100;
    cfg_valid = 1'b1;
    run_count(5, c16, cb, f16, fb);
    check("mid_c16_a", c16, 3);
    check("mid_ready_busy", cfg_ready, 0);
    cfg_valid = 1'b0;
    run_count(16, c16, cb, f16, fb);
    check("mid_c16_b", c16, 8);
    check("mid_firstb", fb, 16);
    check("mid_ready_back", cfg_ready, 1);
    run_count(64, c16, cb, f16, fb);
    check("new_c16", c16, 16);
    check("new_cb", cb, 1);
    check("new_first16", f16, 4);
    check("new_firstb", fb, 64);

    // Resync at an edge that would otherwise carry.
    do_reset();
    cfg_load_idle(16'd32768);
    enable = 1'b1;
    run_count(7, c16, cb, f16, fb);
    resync = 1'b1;
    step();
    resync = 1'b0;
    check("rs_clk16", clk16_en, 0);
    check("rs_clk_en", clk_en, 0);
    run_count(16, c16, cb, f16, fb);
    check("rs_c16", c16, 8);
    check("rs_first16", f16, 2);
    check("rs_firstb", fb, 16);

    // Resync applies a pending increment immediately.
    cfg_send(16'd16384);
    check("rsp_ready_low", cfg_ready, 0);
    resync = 1'b1;
    step();
    resync = 1'b0;
    check("rsp_clk16", clk16_en, 0);
    check("rsp_ready_back", cfg_ready, 1);
    run_count(64, c16, cb, f16, fb);
    check("rsp_c16", c16, 16);
    check("rsp_first16", f16, 4);
    check("rsp_firstb", fb, 32);
    check("rsp_cb", cb, 1);

    // Pause mid-bit for 100 cycles; remaining bit length is preserved.
    do_reset();
    cfg_load_idle(16'd32768);
    enable = 1'b1;
    run_count(11, c16, cb, f16, fb);
    enable = 1'b0;
    run_count(100, c16, cb, f16, fb);
    check("pause_c16", c16, 0);
    check("pause_cb", cb, 0);
    enable = 1'b1;
    run_count(64, c16, cb, f16, fb);
    check("resume_first16", f16, 1);
    check("resume_firstb", fb, 21);
    check("resume_c16", c16, 32);
    check("resume_cb", cb, 2);

    // Asynchronous reset with a pending config.
    do_reset();
    cfg_load_idle(16'd32768);
    enable = 1'b1;
    run_count(9, c16, cb, f16, fb);
    cfg_send(16'd16384);
    check("ar_clk16_pre", clk16_en, 1);
    check("ar_ready_pre", cfg_ready, 0);
    rst_n = 1'b0;
    #1;
    check("ar_clk16", clk16_en, 0);
    check("ar_clk_en", clk_en, 0);
    check("ar_ready", cfg_ready, 1);
    repeat (2) step();
    rst_n = 1'b1;
    run_count(60, c16, cb, f16, fb);
    check("ar_first16", f16, 55);
    check("ar_c16", c16, 1);

    check("orphan_bit_ticks", orphan, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/baud_gen_frac.md
# baud_gen_frac

Fractional-N baud tick generator: next generation of the UART clock-enable divider. It replaces the fixed integer divisor with a phase accumulator, and adds:
- a runtime-programmable increment loaded through a valid/ready handshake,
- a generic oversampling ratio,
- a resync input that aligns the bit tick to a detected start edge.

It sits between the system clock and the UART TX/RX engines, which consume its single-cycle enables.

## Interface
- ACC_WIDTH, 16: phase accumulator width; tick resolution is f_clk/2^ACC_WIDTH.
- OVERSAMP_RATE, 16: oversample ticks per bit tick; must be ≥2.
- DEFAULT_INC, 16'd1208: increment after reset (115200 baud × 16 at 100 MHz, error 0.003%).
- RESYNC_PHASE, OVERSAMP_RATE/2: oversample-counter preset applied on resync.
- clk_i in 1: single system clock, all logic on rising edge.
- reset_n_i in 1: asynchronous, active-low reset.
- enable_i in 1: run; low freezes the accumulator and the counter.
- resync_i in 1: single-cycle pulse that realigns phase.
- cfg_inc_i in ACC_WIDTH: new increment value.
- cfg_valid_i in 1: cfg_inc_i is valid.
- cfg_ready_o out 1: able to accept a new increment.
- clk16_en_o out 1: oversample tick, one cycle wide.
- clk_en_o out 1: bit tick, one cycle wide, coincident with a clk16_en_o.

## Operation
- Reset state:
  - acc=0, os_cnt=0, inc=DEFAULT_INC, no pending increment.
  - clk16_en_o=0, clk_en_o=0, cfg_ready_o=1.
- Accumulator:
  - Each enabled cycle, {carry,acc} ← acc + inc, computed ACC_WIDTH+1 bits wide with modulo wrap.
  - carry=1 produces one oversample tick.
  - Tick rate = f_clk·inc/2^ACC_WIDTH.
  - inc=0 never ticks.
- Oversample counter os_cnt, range 0..OVERSAMP_RATE-1:
  - Increments on each oversample tick and wraps to 0.
  - The tick taken while os_cnt==OVERSAMP_RATE-1 also asserts clk_en_o.
- Configuration handshake:
  - A transfer occurs when cfg_valid_i && cfg_ready_o. cfg_inc_i is captured into a pending register and cfg_ready_o drops the next cycle.
  - The pending value is applied to inc in the cycle clk_en_o is generated (bit boundary), so no bit is stretched.
  - If enable_i=0 or resync_i=1, the pending value is applied the cycle after capture (or in the resync cycle).
  - cfg_ready_o returns to 1 the cycle after application.
  - A new increment never reaches inc without a handshake.
- Resync: when resync_i=1:
  - acc ← 0 and os_cnt ← RESYNC_PHASE; both outputs are 0 next cycle.
  - Any pending increment is applied.
  - Resync acts regardless of enable_i.
- Priority: reset_n_i > resync_i > enable_i.
- Disabled (enable_i=0):
  - acc and os_cnt hold; outputs are 0 next cycle.
  - On re-enable, ticking continues from the held phase.
- Reset mid-operation: asynchronous return to the reset state. A pending increment is discarded and inc reverts to DEFAULT_INC.

## Timing
- Outputs are registered. A carry at edge N is seen as clk16_en_o=1 during cycle N→N+1, i.e. one clock of latency from the accumulator overflow.
- clk_en_o and clk16_en_o are each high for exactly one cycle and never high in consecutive cycles unless inc ≥ 2^(ACC_WIDTH-1).
- Example, inc=2^(ACC_WIDTH-1) from reset:
  - clk16_en_o is high after edges 2, 4, 6, …
  - clk_en_o is high after edge 2·OVERSAMP_RATE.
- After resync at edge R with inc=2^(ACC_WIDTH-1) and RESYNC_PHASE=8, the first clk_en_o follows edge R+16.
- The increment applied at the bit-tick edge governs accumulation from the following edge onward.

## Structure
- Shared package uart_pkg holds:
  - ACC_WIDTH default and OVERSAMP_RATE default;
  - the DEFAULT_INC constant;
  - a constant function baud_inc(clk_hz, baud, osr, acc_w) returning round(baud·osr·2^acc_w/clk_hz).
- One natural sub-module, phase_acc:
  - holds the accumulator register and the carry output;
  - is parameterised by ACC_WIDTH;
  - has inputs en, clr and inc.
- The top level contains os_cnt, the config shadow/handshake logic, and the output registers.

## Test plan
- Reset, then enable with default inc=1208, ACC_WIDTH=16, over 10^6 cycles → 18432 ±1 clk16_en_o pulses and 1152 ±1 clk_en_o pulses; every clk_en_o coincides with a clk16_en_o.
- Handshake inc=32768 → clk16_en_o every 2 cycles and clk_en_o every 32 cycles. Handshake inc=0 while enabled → ticks stop only after the next bit tick; cfg_ready_o low until then.
- Config while running: send inc=16384 mid-bit → the current bit keeps the old rate, and the new period (64 cycles per bit) starts exactly at the clk_en_o edge. Assert cfg_valid_i while cfg_ready_o=0 → no capture.
- Resync with inc=32768 at edge R → no outputs for one cycle, first clk_en_o after edge R+16. Resync coincident with a pending config → new inc used immediately.
- enable_i low for 100 cycles mid-bit → no pulses and phase held; after re-enable, the remaining bit length equals the pre-pause remainder.
- Assert reset_n_i low mid-bit with a pending config → all outputs 0 immediately, cfg_ready_o=1, inc=DEFAULT_INC after release.
